// File: rtl/bit_serial_alu_ctrl_if.sv
// Bundle of all request, response and ALU-cell signals of bit_serial_alu_ctrl.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both 1. The sender holds valid and its
// payload stable until that edge. The receiver may move ready at any time.
// Here req_ready depends only on controller state, never on req_valid.
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 4
);
  // requester -> controller
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  // controller -> consumer
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_ovf;
  logic             rsp_zero;
  logic             busy;
  // controller <-> 1-bit ALU cell
  logic             cell_a;
  logic             cell_b;
  logic             cell_cin;
  logic [1:0]       cell_op;
  logic             cell_y;
  logic             cell_cout;
  // FSM state for observation: 0 IDLE, 1 RUN, 2 DONE
  logic [1:0]       dbg_state;

  // controller side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, cell_y, cell_cout,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero,
           busy, cell_a, cell_b, cell_cin, cell_op, dbg_state
  );

  // environment side: requester, consumer and the cell
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, cell_y, cell_cout,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero,
           busy, cell_a, cell_b, cell_cin, cell_op, dbg_state
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer. It runs one WIDTH-bit operation through an external
// 1-bit ALU cell, one bit per cycle, LSB first. It keeps the ripple carry in
// its own register and returns the result and flags over a valid/ready response.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  reset,  // asynchronous, active low
  bit_serial_alu_ctrl_if.slave bus
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [1:0] CELL_SUM = 2'b00;
  localparam logic [1:0] CELL_AND = 2'b01;
  localparam logic [1:0] CELL_OR  = 2'b10;
  localparam logic [1:0] CELL_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             req_ready_w;
  logic             cell_a_w, cell_b_w, cell_cin_w;
  logic [1:0]       cell_op_w;
  logic             arith_w;

  // Only ADD, SUB and INC use the carry chain.
  assign arith_w = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_INC);

  // State register and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // Next-state, cell drive and response logic for IDLE -> RUN -> DONE.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready_w  = 1'b0;
    cell_a_w     = 1'b0;
    cell_b_w     = 1'b0;
    cell_cin_w   = 1'b0;
    cell_op_w    = CELL_SUM;

    case (state_q)
      S_IDLE: begin
        req_ready_w = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          idx_d   = '0;
          res_d   = '0;
          // SUB is A + ~B + 1 and INC is A + 0 + 1, so both start with carry set.
          carry_d = (bus.req_op == OP_SUB) || (bus.req_op == OP_INC);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cell_a_w = a_q[idx_q];
        case (op_q)
          OP_ADD:  begin cell_op_w = CELL_SUM; cell_b_w = b_q[idx_q];  end
          OP_SUB:  begin cell_op_w = CELL_SUM; cell_b_w = ~b_q[idx_q]; end
          OP_INC:  begin cell_op_w = CELL_SUM; cell_b_w = 1'b0;        end
          OP_AND:  begin cell_op_w = CELL_AND; cell_b_w = b_q[idx_q];  end
          OP_OR:   begin cell_op_w = CELL_OR;  cell_b_w = b_q[idx_q];  end
          OP_XOR:  begin cell_op_w = CELL_XOR; cell_b_w = b_q[idx_q];  end
          OP_NOT:  begin cell_op_w = CELL_XOR; cell_b_w = 1'b1;        end
          OP_PASS: begin cell_op_w = CELL_OR;  cell_b_w = 1'b0;        end
          default: begin cell_op_w = CELL_SUM; cell_b_w = 1'b0;        end
        endcase
        cell_cin_w = arith_w ? carry_q : 1'b0;

        res_d[idx_q] = bus.cell_y;
        if (arith_w) begin
          carry_d = bus.cell_cout;
        end

        if (idx_q == IDX_LAST) begin
          // On this cycle carry_q is the carry into the MSB and cell_cout is
          // the carry out of it. Their XOR is the signed overflow.
          idx_d        = '0;
          state_d      = S_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = res_d;
          rsp_carry_d  = arith_w ? bus.cell_cout : 1'b0;
          rsp_ovf_d    = arith_w ? (carry_q ^ bus.cell_cout) : 1'b0;
          rsp_zero_d   = ~|res_d;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d      = S_IDLE;
          rsp_valid_d  = 1'b0;
          rsp_result_d = '0;
          rsp_carry_d  = 1'b0;
          rsp_ovf_d    = 1'b0;
          rsp_zero_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cell_a     = cell_a_w;
  assign bus.cell_b     = cell_b_w;
  assign bus.cell_cin   = cell_cin_w;
  assign bus.cell_op    = cell_op_w;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed testbench for bit_serial_alu_ctrl. It uses a behavioural 1-bit cell,
// a WIDTH=4 instance for most steps, and a WIDTH=8 instance for the wide add.
module tb_bit_serial_alu_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bit_serial_alu_ctrl_if #(.WIDTH(4)) bus4 ();
  bit_serial_alu_ctrl_if #(.WIDTH(8)) bus8 ();

  bit_serial_alu_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .reset(rst_n), .bus(bus4));
  bit_serial_alu_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst_n), .bus(bus8));

  // Behavioural ALU cells: full adder plus and/or/xor, muxed on cell_op.
  assign bus4.cell_y = (bus4.cell_op == 2'b00) ? (bus4.cell_a ^ bus4.cell_b ^ bus4.cell_cin) :
                       (bus4.cell_op == 2'b01) ? (bus4.cell_a & bus4.cell_b) :
                       (bus4.cell_op == 2'b10) ? (bus4.cell_a | bus4.cell_b) :
                                                 (bus4.cell_a ^ bus4.cell_b);
  assign bus4.cell_cout = (bus4.cell_a & bus4.cell_b) | (bus4.cell_a & bus4.cell_cin) |
                          (bus4.cell_b & bus4.cell_cin);
  assign bus8.cell_y = (bus8.cell_op == 2'b00) ? (bus8.cell_a ^ bus8.cell_b ^ bus8.cell_cin) :
                       (bus8.cell_op == 2'b01) ? (bus8.cell_a & bus8.cell_b) :
                       (bus8.cell_op == 2'b10) ? (bus8.cell_a | bus8.cell_b) :
                                                 (bus8.cell_a ^ bus8.cell_b);
  assign bus8.cell_cout = (bus8.cell_a & bus8.cell_b) | (bus8.cell_a & bus8.cell_cin) |
                          (bus8.cell_b & bus8.cell_cin);

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the 4-bit instance for one edge, then drop it.
  task automatic start4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus4.req_op    = op;
    bus4.req_a     = a;
    bus4.req_b     = b;
    bus4.req_valid = 1'b1;
    tick();
    bus4.req_valid = 1'b0;
    bus4.req_a     = 4'h0;
    bus4.req_b     = 4'h0;
  endtask

  // Wait (bounded) for the response, check it, then complete the handshake.
  task automatic finish4(input string tag, input logic [3:0] exp_res,
                         input logic exp_c, input logic exp_o);
    int n;
    n = 0;
    while (!bus4.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " result"}, bus4.rsp_result, exp_res);
    chk({tag, " carry"}, bus4.rsp_carry, exp_c);
    chk({tag, " ovf"}, bus4.rsp_ovf, exp_o);
    chk({tag, " zero"}, bus4.rsp_zero, (exp_res == 4'h0));
    bus4.rsp_ready = 1'b1;
    tick();
    bus4.rsp_ready = 1'b0;
    chk({tag, " rsp_valid cleared"}, bus4.rsp_valid, 1'b0);
    chk({tag, " req_ready back"}, bus4.req_ready, 1'b1);
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_op = 3'b000; bus4.req_a = 4'h0; bus4.req_b = 4'h0;
    bus4.rsp_ready = 1'b0;
    bus8.req_valid = 1'b0; bus8.req_op = 3'b000; bus8.req_a = 8'h00; bus8.req_b = 8'h00;
    bus8.rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("rst rsp_valid", bus4.rsp_valid, 1'b0);
    chk("rst busy", bus4.busy, 1'b0);
    chk("rst cell", {bus4.cell_a, bus4.cell_b, bus4.cell_cin, bus4.cell_op}, 5'b0);
    chk("rst rsp fields", {bus4.rsp_result, bus4.rsp_carry, bus4.rsp_ovf, bus4.rsp_zero}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst req_ready", bus4.req_ready, 1'b1);

    // ADD 7+9 = 0x10: result 0, carry out, zero, no signed overflow.
    start4(3'b000, 4'h7, 4'h9);
    chk("add busy", bus4.busy, 1'b1);
    chk("add req_ready low", bus4.req_ready, 1'b0);
    chk("add cell idx0", {bus4.cell_a, bus4.cell_b, bus4.cell_cin, bus4.cell_op}, 5'b11000);
    finish4("add 7+9", 4'h0, 1'b1, 1'b0);

    // SUB 3-5: A=0011, ~B=1010, cin=1 -> 1110, no carry (borrow).
    start4(3'b001, 4'h3, 4'h5);
    chk("sub cell idx0", {bus4.cell_a, bus4.cell_b, bus4.cell_cin, bus4.cell_op}, 5'b10100);
    finish4("sub 3-5", 4'hE, 1'b0, 1'b0);

    // SUB 8-1: -8 - 1 overflows to +7, no borrow.
    start4(3'b001, 4'h8, 4'h1);
    finish4("sub 8-1", 4'h7, 1'b1, 1'b1);

    // INC 7 -> 8 overflows; B is ignored.
    start4(3'b110, 4'h7, 4'hF);
    finish4("inc 7", 4'h8, 1'b0, 1'b1);

    // Logic ops: carry and ovf are forced to 0.
    start4(3'b010, 4'hC, 4'hA);
    chk("and cell idx0", {bus4.cell_b, bus4.cell_cin, bus4.cell_op}, 4'b0001);
    finish4("and", 4'h8, 1'b0, 1'b0);
    start4(3'b011, 4'hC, 4'hA);
    finish4("or", 4'hE, 1'b0, 1'b0);
    start4(3'b100, 4'hC, 4'hA);
    finish4("xor", 4'h6, 1'b0, 1'b0);
    start4(3'b101, 4'h5, 4'h3);
    chk("not cell idx0", {bus4.cell_b, bus4.cell_op}, 3'b111);
    finish4("not 5", 4'hA, 1'b0, 1'b0);
    start4(3'b111, 4'h3, 4'hF);
    chk("pass cell idx0", {bus4.cell_b, bus4.cell_op}, 3'b010);
    finish4("pass 3", 4'h3, 1'b0, 1'b0);

    // Back-pressure: response held 10 cycles while a second request waits.
    start4(3'b000, 4'h2, 4'h3);
    n = 0;
    while (!bus4.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall latency", n, 4);
    bus4.req_op    = 3'b000;
    bus4.req_a     = 4'h1;
    bus4.req_b     = 4'h1;
    bus4.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall rsp_valid held", bus4.rsp_valid, 1'b1);
      chk("stall result held", bus4.rsp_result, 4'h5);
      chk("stall req_ready low", bus4.req_ready, 1'b0);
    end
    chk("stall state DONE", bus4.dbg_state, 2'd2);
    bus4.rsp_ready = 1'b1;
    tick();
    bus4.rsp_ready = 1'b0;
    chk("handshake edge no accept", bus4.busy, 1'b0);
    chk("handshake rsp_valid low", bus4.rsp_valid, 1'b0);
    tick();
    bus4.req_valid = 1'b0;
    chk("second req accepted", bus4.busy, 1'b1);
    finish4("second add 1+1", 4'h2, 1'b0, 1'b0);

    // Asynchronous reset mid-operation at idx=2.
    start4(3'b000, 4'h5, 4'h6);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst cell", {bus4.cell_a, bus4.cell_b, bus4.cell_cin, bus4.cell_op}, 5'b0);
    chk("mid-rst rsp_valid", bus4.rsp_valid, 1'b0);
    chk("mid-rst busy", bus4.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start4(3'b000, 4'h1, 4'h1);
    finish4("after-rst add 1+1", 4'h2, 1'b0, 1'b0);

    // WIDTH=8: ADD 0xFF+0x01 wraps to zero with carry, 8-cycle latency.
    bus8.req_op    = 3'b000;
    bus8.req_a     = 8'hFF;
    bus8.req_b     = 8'h01;
    bus8.req_valid = 1'b1;
    tick();
    bus8.req_valid = 1'b0;
    n = 0;
    while (!bus8.rsp_valid && n < 30) begin
      tick();
      n++;
    end
    chk("w8 latency", n, 8);
    chk("w8 result", bus8.rsp_result, 8'h00);
    chk("w8 carry", bus8.rsp_carry, 1'b1);
    chk("w8 zero", bus8.rsp_zero, 1'b1);
    chk("w8 ovf", bus8.rsp_ovf, 1'b0);
    bus8.rsp_ready = 1'b1;
    tick();
    bus8.rsp_ready = 1'b0;
    chk("w8 rsp_valid cleared", bus8.rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
